load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WORD_SIZE, 32, data/address width; only 32 is supported.
REQ-002 Parameter MEM_SIZE, 1024, number of words in the attached memory.
REQ-003 One clock, clk_i; reset is asynchronous and active-low, rst_ni.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 req_valid_i  in  1  pipeline request strobe.
REQ-007 req_ready_o  out  1  high only in IDLE; a request is accepted on a clock edge where req_valid_i && req_ready_o.
REQ-008 req_we_i  in  1  1 = store, 0 = load.
REQ-009 req_funct3_i  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_base_i  in  32  rs1 value (byte address base).
REQ-011 req_offset_i  in  32  sign-extended immediate.
REQ-012 req_wdata_i  in  32  rs2 store data; low bits are used for B/H.
REQ-013 resp_valid_o  out  1  one-cycle completion pulse.
REQ-014 resp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-015 resp_err_o  out  1  misaligned, out-of-range or illegal-funct3 request; valid with resp_valid_o.
REQ-016 en_mem_o  out  1  memory strobe; the memory acts on its rising edge.
REQ-017 mem_read_o, mem_write_o  out  1 each  memory operation select.
REQ-018 mem_addr_base_o  out  32  word index; mem_addr_offset_o  out  32  is tied to 0.
REQ-019 mem_val_o  out  32  memory write data; mem_val_i  in  32  memory read data.

Function
REQ-020 Byte address EA = req_base_i + req_offset_i, modulo 2^32; word index = EA[31:2]; lane = EA[1:0], little-endian (lane 0 = bits 7:0).
REQ-021 Error cases: H/HU with EA[0]=1; W with EA[1:0]!=0; word index >= MEM_SIZE; funct3 not in {000,001,010,100,101}; a store with funct3 100 or 101.
REQ-022 States: IDLE, RD_EN, RD_WAIT, WR_EN, RESP.
REQ-023 On accept, the unit registers the word index, lane, funct3, we and wdata; all mem_* outputs are driven from registers and stay stable from the accept edge until IDLE is re-entered.
REQ-024 IDLE -> RESP on an error request (resp_err_o=1, no en_mem_o pulse); -> WR_EN on a W store; -> RD_EN on loads and B/H stores.
REQ-025 RD_EN: en_mem_o=1 and mem_read_o=1 for exactly one cycle, then -> RD_WAIT.
REQ-026 RD_WAIT: en_mem_o=0; capture mem_val_i. A load -> RESP with extracted, extended data. A B/H store merges wdata into the captured lane(s) -> WR_EN.
REQ-027 WR_EN: en_mem_o=1 and mem_write_o=1 for exactly one cycle, with mem_val_o holding the merged or full word, then -> RESP.
REQ-028 RESP: resp_valid_o=1 for one cycle, then -> IDLE; there is no response backpressure.
REQ-029 Two en_mem_o pulses are always separated by at least one low cycle.
REQ-030 Latency from accept edge to resp_valid_o: load 3 cycles, W store 2, B/H store 4, error 1.
REQ-031 LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
REQ-032 req_valid_i outside IDLE is ignored; no queuing.

Reset
REQ-033 rst_ni low asynchronously forces IDLE and drives all outputs to 0 except req_ready_o, which is 1.
REQ-034 Reset during any state aborts the access; a WR_EN cut short by reset leaves memory either unchanged or fully written, never partially merged.

Structure
REQ-035 Package lsu_pkg holds the state enum, the funct3 constants and the WORD_SIZE default.
REQ-036 One combinational sub-module, lsu_align, performs lane extract/extend and store merge.

Verification
REQ-037 Memory word 5 = 0x8899AABB; LB with EA=0x15 -> RD_EN, then resp_rdata_o=0xFFFFFFAA at accept+3 cycles, resp_err_o=0.
REQ-038 SW 0xDEADBEEF with base 0x100, offset -4 -> single write pulse to index 0x3F, response at +2; a following LW returns 0xDEADBEEF.
REQ-039 Word 2 = 0x11223344; SH 0xABCD with EA=0xA -> read pulse, then write pulse with mem_val_o=0xABCD3344, response at +4.
REQ-040 LW with EA=0x6, and LW with EA=4*MEM_SIZE -> resp_err_o=1 at +1, en_mem_o never rises.
REQ-041 rst_ni dropped during RD_WAIT of an SB -> outputs clear immediately, no write pulse; after release req_ready_o=1 and the memory word is unchanged.
REQ-042 req_valid_i held high through a 4-cycle store -> exactly one accept; a second request is accepted only in the cycle after resp_valid_o.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// width codes and request-legality helpers.
package lsu_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int MEM_SIZE_DEF  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_EN   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_EN   = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads; stores with them are rejected.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = lane[0];
      F3_W:        bad = (lane != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and read-modify-write
// merge of byte/halfword store data into a fetched word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [4:0]  shamt_s;

  assign shamt_s = {lane_i, 3'b000};
  assign half_s  = lane_i[1] ? word_i[31:16] : word_i[15:0];

  // Select the addressed byte lane (little-endian).
  always_comb begin
    byte_s = 8'h00;
    case (lane_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Extend loaded data and build the merged store word.
  always_comb begin
    load_data_o = 32'h0000_0000;
    merged_o    = word_i;
    case (funct3_i)
      F3_B: begin
        load_data_o = {{24{byte_s[7]}}, byte_s};
        merged_o    = (word_i & ~(32'h0000_00FF << shamt_s))
                    | ({24'h00_0000, wdata_i[7:0]} << shamt_s);
      end
      F3_H: begin
        load_data_o = {{16{half_s[15]}}, half_s};
        merged_o    = (word_i & ~(32'h0000_FFFF << shamt_s))
                    | ({16'h0000, wdata_i[15:0]} << shamt_s);
      end
      F3_W: begin
        load_data_o = word_i;
        merged_o    = wdata_i;
      end
      F3_BU: begin
        load_data_o = {24'h00_0000, byte_s};
        merged_o    = word_i;
      end
      F3_HU: begin
        load_data_o = {16'h0000, half_s};
        merged_o    = word_i;
      end
      default: begin
        load_data_o = 32'h0000_0000;
        merged_o    = word_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a strobe-triggered word
// memory; B/H stores are done as read-modify-write so the memory only sees whole words.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [WORD_SIZE-1:0] req_base_i,
  input  logic [WORD_SIZE-1:0] req_offset_i,
  input  logic [WORD_SIZE-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  output logic [WORD_SIZE-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 en_mem_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [WORD_SIZE-1:0] mem_addr_base_o,
  output logic [WORD_SIZE-1:0] mem_addr_offset_o,
  output logic [WORD_SIZE-1:0] mem_val_o,
  input  logic [WORD_SIZE-1:0] mem_val_i
);

  localparam logic [WORD_SIZE-1:0] MEM_LIMIT = WORD_SIZE'(MEM_SIZE);
  localparam logic [WORD_SIZE-1:0] ZERO_W    = {WORD_SIZE{1'b0}};

  lsu_state_e state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [1:0]           lane_q, lane_d;
  logic [2:0]           f3_q, f3_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] mem_val_q, mem_val_d;
  logic                 en_q, en_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 ready_q, ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;

  logic [WORD_SIZE-1:0] ea_s;
  logic [WORD_SIZE-1:0] widx_s;
  logic                 req_err_s;
  logic                 accept_s;
  logic [31:0]          load_data_s;
  logic [31:0]          merged_s;

  assign ea_s      = req_base_i + req_offset_i;
  assign widx_s    = {2'b00, ea_s[WORD_SIZE-1:2]};
  assign req_err_s = f3_illegal(req_funct3_i, req_we_i)
                   | f3_misaligned(req_funct3_i, ea_s[1:0])
                   | (widx_s >= MEM_LIMIT);
  assign accept_s  = req_valid_i & ready_q;

  lsu_align u_align (
    .funct3_i    (f3_q),
    .lane_i      (lane_q),
    .word_i      (mem_val_i),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  // Next-state and next-output computation; outputs follow the next state so they are registered.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    f3_d         = f3_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_val_d    = mem_val_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = ZERO_W;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d    = widx_s;
          lane_d    = ea_s[1:0];
          f3_d      = req_funct3_i;
          we_d      = req_we_i;
          wdata_d   = req_wdata_i;
          mem_val_d = (req_we_i && (req_funct3_i == F3_W)) ? req_wdata_i : ZERO_W;
          if (req_err_s) begin
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else if (req_we_i && (req_funct3_i == F3_W)) begin
            state_d = ST_WR_EN;
          end else begin
            state_d = ST_RD_EN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_EN:   state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (we_q) begin
          mem_val_d = merged_s;
          state_d   = ST_WR_EN;
        end else begin
          resp_rdata_d = load_data_s;
          state_d      = ST_RESP;
        end
      end
      ST_WR_EN:   state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    en_d         = (state_d == ST_RD_EN) || (state_d == ST_WR_EN);
    rd_d         = (state_d == ST_RD_EN);
    wr_d         = (state_d == ST_WR_EN);
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      addr_q       <= ZERO_W;
      lane_q       <= 2'b00;
      f3_q         <= 3'b000;
      we_q         <= 1'b0;
      wdata_q      <= ZERO_W;
      mem_val_q    <= ZERO_W;
      en_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= ZERO_W;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_val_q    <= mem_val_d;
      en_q         <= en_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready_o       = ready_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_err_o        = resp_err_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign en_mem_o          = en_q;
  assign mem_read_o        = rd_q;
  assign mem_write_o       = wr_q;
  assign mem_addr_base_o   = addr_q;
  assign mem_addr_offset_o = ZERO_W;
  assign mem_val_o         = mem_val_q;

endmodule
